clb_cfg_loader: RTL and testbench

//  Configuration loader sitting directly upstream of the CLB logical cells.

---
 rtl/clb_cfg_loader_pkg.sv | 31 +++
 rtl/clb_cfg_loader_if.sv | 17 +
 rtl/clb_cfg_loader_shadow.sv | 35 +++
 rtl/clb_cfg_loader.sv | 104 ++++++++++
 tb/tb_clb_cfg_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clb_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module : clb_cfg_loader_pkg
//  Brief  : Shared CLB config-word layout, reset word and loader state encoding
//  Rev    : 1.0  initial release
// ============================================================================
package clb_cfg_loader_pkg;

  localparam int CFG_W   = 9;
  localparam int BYP_BIT = 8;
  localparam int SEL_W   = 3;
  localparam int OP_W    = 2;
  localparam int SEL0_LO = 5;
  localparam int SEL1_LO = 2;
  localparam int OP_LO   = 0;

  // Bypass set, all selects zero: every cell passes in0.
  localparam logic [CFG_W-1:0] CFG_RESET = 9'h100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clb_cfg_loader_if.sv
`default_nettype none
// ============================================================================
//  Module : clb_cfg_loader_if
//  Brief  : Valid/ready config-word stream into the CLB config loader
//  Rev    : 1.0  initial release
// ============================================================================
interface clb_cfg_loader_if;

  logic                                 cfg_valid;
  logic [clb_cfg_loader_pkg::CFG_W-1:0] cfg_data;
  logic                                 cfg_ready;

  modport master (output cfg_valid, output cfg_data, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_data, output cfg_ready);

endinterface
`default_nettype wire

// File: rtl/clb_cfg_loader_shadow.sv
`default_nettype none
// ============================================================================
//  Module : clb_cfg_shadow
//  Brief  : NUM_CELLS x CFG_W shadow register file, indexed write, flat read-all
//  Rev    : 1.0  initial release
// ============================================================================
module clb_cfg_shadow #(
  parameter int NUM_CELLS = 4,
  parameter int CFG_W     = 9,
  parameter int IDX_W     = 2
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       we,
  input  wire logic [IDX_W-1:0]           widx,
  input  wire logic [CFG_W-1:0]           wdata,
  output logic      [NUM_CELLS*CFG_W-1:0] rdata
);

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    logic [CFG_W-1:0] r_word;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_word <= '0;
      end else if (we && (widx == IDX_W'(i))) begin
        r_word <= wdata;
      end
    end

    assign rdata[i*CFG_W +: CFG_W] = r_word;
  end

endmodule
`default_nettype wire

// File: rtl/clb_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module : clb_cfg_loader
//  Brief  : Streams per-cell config words into shadow regs, commits atomically
//  Rev    : 1.0  initial release
// ============================================================================
module clb_cfg_loader #(
  parameter int NUM_CELLS = 4,
  parameter int CFG_W     = 9
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic             abort,
  clb_cfg_loader_if.slave       cfg,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_CELLS-1:0]  byPass,
  output logic [3*NUM_CELLS-1:0] sel0,
  output logic [3*NUM_CELLS-1:0] sel1,
  output logic [2*NUM_CELLS-1:0] selOp
);
  import clb_cfg_loader_pkg::*;

  localparam int               c_idx_w = idx_width(NUM_CELLS);
  localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(NUM_CELLS - 1);
  localparam logic [c_idx_w-1:0] c_one   = c_idx_w'(1);

  state_t                       r_state;
  logic [c_idx_w-1:0]           r_idx;
  logic                         r_done;
  logic [NUM_CELLS*CFG_W-1:0]   r_active;
  logic [NUM_CELLS*CFG_W-1:0]   w_shadow;
  logic                         w_hs;

  // Abort wins over a valid word in the same cycle by withdrawing ready.
  assign cfg.cfg_ready = (r_state == ST_LOAD) && !abort;
  assign w_hs          = cfg.cfg_valid && cfg.cfg_ready;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

  clb_cfg_shadow #(
    .NUM_CELLS (NUM_CELLS),
    .CFG_W     (CFG_W),
    .IDX_W     (c_idx_w)
  ) u_shadow (
    .clk   (clk),
    .reset (reset),
    .we    (w_hs),
    .widx  (r_idx),
    .wdata (cfg.cfg_data),
    .rdata (w_shadow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_active <= {NUM_CELLS{CFG_RESET}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end else if (w_hs) begin
            if (r_idx == c_last) begin
              r_state <= ST_COMMIT;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + c_one;
            end
          end
        end
        ST_COMMIT: begin
          r_active <= w_shadow;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_unpack
    assign byPass[i]           = r_active[i*CFG_W + BYP_BIT];
    assign sel0[3*i +: SEL_W]  = r_active[i*CFG_W + SEL0_LO +: SEL_W];
    assign sel1[3*i +: SEL_W]  = r_active[i*CFG_W + SEL1_LO +: SEL_W];
    assign selOp[2*i +: OP_W]  = r_active[i*CFG_W + OP_LO   +: OP_W];
  end

endmodule
`default_nettype wire

// File: tb/tb_clb_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module : tb_clb_cfg_loader
//  Brief  : Self-checking bench for clb_cfg_loader (NUM_CELLS=4)
//  Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clb_cfg_loader;

  localparam int NC = 4;

  typedef logic [8:0] word_t;
  typedef struct packed {
    logic [NC-1:0]   byp;
    logic [3*NC-1:0] s0;
    logic [3*NC-1:0] s1;
    logic [2*NC-1:0] op;
  } act_t;
  typedef struct {
    word_t w [NC];
    bit    gaps;
    act_t  exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset, start, abort;
  logic            busy, done;
  logic [NC-1:0]   byPass;
  logic [3*NC-1:0] sel0, sel1;
  logic [2*NC-1:0] selOp;

  clb_cfg_loader_if ifc ();

  clb_cfg_loader #(.NUM_CELLS(NC), .CFG_W(9)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .cfg    (ifc),
    .busy   (busy),
    .done   (done),
    .byPass (byPass),
    .sel0   (sel0),
    .sel1   (sel1),
    .selOp  (selOp)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  act_t sb [$];
  act_t cur;
  act_t rst_act;
  vec_t vt [4];

  // Reference unpack of the config word layout, cell 0 in the LSBs.
  function automatic act_t model(input word_t w [NC]);
    act_t m;
    m = '0;
    for (int i = 0; i < NC; i++) begin
      m.byp[i]      = w[i][8];
      m.s0[3*i +: 3] = w[i][7:5];
      m.s1[3*i +: 3] = w[i][4:2];
      m.op[2*i +: 2] = w[i][1:0];
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input act_t e);
    chk({name, "_byPass"}, 64'(byPass), 64'(e.byp));
    chk({name, "_sel0"},   64'(sel0),   64'(e.s0));
    chk({name, "_sel1"},   64'(sel1),   64'(e.s1));
    chk({name, "_selOp"},  64'(selOp),  64'(e.op));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ready_after_start", 64'(ifc.cfg_ready), 64'(1));
  endtask

  // Present words until `count` handshakes complete; outputs must hold meanwhile.
  task automatic feed(input word_t w [NC], input int count, input bit gaps, input bit hold_start);
    int n;
    int cyc;
    bit hs;
    n   = 0;
    cyc = 0;
    while (n < count && cyc < 200) begin
      ifc.cfg_valid = gaps ? cyc[0] : 1'b1;
      ifc.cfg_data  = w[n];
      start         = hold_start;
      hs            = ifc.cfg_valid && ifc.cfg_ready;
      chk_out("hold", cur);
      step();
      if (hs) n++;
      cyc++;
    end
    ifc.cfg_valid = 1'b0;
    if (n < count) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got %0d handshakes expected %0d", n, count);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending load.
  always @(negedge clk) begin
    act_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk_out("commit", e);
        cur = e;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_act     = '0;
    rst_act.byp = '1;
    cur         = rst_act;

    vt[0].w = '{9'h100, 9'h02B, 9'h0D6, 9'h1FF}; vt[0].gaps = 1'b0;
    vt[1].w = '{9'h100, 9'h02B, 9'h0D6, 9'h1FF}; vt[1].gaps = 1'b1;
    vt[2].w = '{9'h0AA, 9'h155, 9'h000, 9'h1C3}; vt[2].gaps = 1'b0;
    vt[3].w = '{9'h1FF, 9'h0F0, 9'h10F, 9'h033}; vt[3].gaps = 1'b1;
    for (int i = 0; i < 4; i++) vt[i].exp = model(vt[i].w);

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    ifc.cfg_valid = 1'b0; ifc.cfg_data = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_out("reset", rst_act);
    chk("reset_ready", 64'(ifc.cfg_ready), 64'(0));
    chk("reset_busy",  64'(busy), 64'(0));
    chk("reset_done",  64'(done), 64'(0));

    // Table-driven full loads, back-to-back and with valid gaps.
    for (int i = 0; i < 4; i++) begin
      start_pulse();
      feed(vt[i].w, NC, vt[i].gaps, 1'b0);
      sb.push_back(vt[i].exp);
      chk("commit_busy",  64'(busy), 64'(1));
      chk("commit_ready", 64'(ifc.cfg_ready), 64'(0));
      chk("commit_done",  64'(done), 64'(0));
      step();
      chk("done_latency", 64'(done), 64'(1));
      step();
      chk("done_pulse",   64'(done), 64'(0));
    end

    // Abort after two words: abort beats valid, nothing commits.
    start_pulse();
    feed(vt[2].w, 2, 1'b0, 1'b0);
    abort = 1'b1; ifc.cfg_valid = 1'b1; ifc.cfg_data = 9'h0F0;
    #1;
    chk("abort_ready", 64'(ifc.cfg_ready), 64'(0));
    step();
    abort = 1'b0; ifc.cfg_valid = 1'b0;
    chk("abort_idle", 64'(busy), 64'(0));
    repeat (3) step();
    chk_out("abort_hold", cur);
    start_pulse();
    feed(vt[2].w, NC, 1'b0, 1'b0);
    sb.push_back(vt[2].exp);
    step(); step();

    // start held through LOAD and COMMIT: no restart; start in done cycle accepted.
    start = 1'b1;
    step();
    chk("hold_start_ready", 64'(ifc.cfg_ready), 64'(1));
    feed(vt[0].w, NC, 1'b0, 1'b1);
    sb.push_back(vt[0].exp);
    chk("hold_start_commit", 64'(busy), 64'(1));
    step();
    chk("commit_start_ignored", 64'(busy), 64'(0));
    chk("commit_start_done",    64'(done), 64'(1));
    step();
    start = 1'b0;
    chk("done_cycle_start", 64'(ifc.cfg_ready), 64'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("done_cycle_abort", 64'(busy), 64'(0));

    // Reset after the third handshake, then a stray word without start.
    start_pulse();
    feed(vt[3].w, 3, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cur = rst_act;
    chk_out("midload_reset", rst_act);
    chk("midload_reset_busy",  64'(busy), 64'(0));
    ifc.cfg_valid = 1'b1; ifc.cfg_data = 9'h0AB;
    #1;
    chk("stray_word_ready", 64'(ifc.cfg_ready), 64'(0));
    step();
    ifc.cfg_valid = 1'b0;
    chk("stray_word_idle", 64'(busy), 64'(0));
    chk_out("stray_word_hold", rst_act);

    start_pulse();
    feed(vt[3].w, NC, 1'b0, 1'b0);
    sb.push_back(vt[3].exp);
    step(); step();

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
